// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and ctrl-bundle field indices for the 5-stage pipe registers
package pipe_pkg;

    // Payload widths per stage boundary
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_DATA_W  = 64;
    localparam int EXMEM_DATA_W = 64;
    localparam int MEMWB_DATA_W = 64;

    localparam int IFID_CTRL_W  = 8;
    localparam int IDEX_CTRL_W  = 8;
    localparam int EXMEM_CTRL_W = 8;
    localparam int MEMWB_CTRL_W = 8;

    // Bit positions inside the ctrl bundle
    localparam int CTRL_REG_WR  = 0;
    localparam int CTRL_MEM2REG = 1;
    localparam int CTRL_JAL     = 2;
    localparam int CTRL_BR      = 3;

endpackage

// File: rtl/ff_en.sv
// rtl/ff_en.sv - enabled register with synchronous active-high clear
module ff_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with flush, optional skid entry and stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_xfer;
    logic              out_xfer;
    logic              load_in;
    logic              load_skid;
    logic              main_en;
    logic              ctrl_clr;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_d;

    assign out_valid = main_valid;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_valid & out_ready;
    assign ctrl_clr  = rst | flush;

    // Skid refill and direct input load are mutually exclusive: in_ready is low while skid is held
    assign load_skid = skid_valid & out_ready & ~flush;
    assign load_in   = in_xfer & (~main_valid | out_ready) & ~flush;
    assign main_en   = load_in | load_skid;

    assign main_data_d = load_skid ? skid_data : in_data;
    assign main_ctrl_d = main_en ? (load_skid ? skid_ctrl : in_ctrl) : '0;

    ff_en #(.W(DATA_W)) u_main_data (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_data_d),
        .q   (out_data)
    );

    // Ctrl is rewritten with zero whenever the entry drains, so a bubble never carries live controls
    ff_en #(.W(CTRL_W)) u_main_ctrl (
        .clk (clk),
        .rst (ctrl_clr),
        .en  (main_en | out_xfer),
        .d   (main_ctrl_d),
        .q   (out_ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
        end else if (main_en) begin
            main_valid <= 1'b1;
        end else if (out_xfer) begin
            main_valid <= 1'b0;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic skid_load;

            assign skid_load = in_xfer & main_valid & ~out_ready & ~flush;
            assign in_ready  = ~skid_valid;

            ff_en #(.W(DATA_W)) u_skid_data (
                .clk (clk),
                .rst (rst),
                .en  (skid_load),
                .d   (in_data),
                .q   (skid_data)
            );

            ff_en #(.W(CTRL_W)) u_skid_ctrl (
                .clk (clk),
                .rst (ctrl_clr),
                .en  (skid_load),
                .d   (in_ctrl),
                .q   (skid_ctrl)
            );

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    skid_valid <= 1'b0;
                end else if (skid_load) begin
                    skid_valid <= 1'b1;
                end else if (load_skid) begin
                    skid_valid <= 1'b0;
                end
            end
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
            assign in_ready   = out_ready | ~main_valid;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && !flush && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
